toggle_event_rx: RTL

//   Receive end of a toggle-encoded event link. The sending domain flips a level (T flip-flop, reset 0)

---
 rtl/toggle_rx_pkg.sv | 16 +
 rtl/sync_ff_chain.sv | 24 ++
 rtl/toggle_event_rx.sv | 111 +++++++++++
 3 files changed

// File: rtl/toggle_rx_pkg.sv
// Shared defaults and state encoding for the toggle-encoded event receiver.
// Build option TOGGLE_RX_ACK_EN enables the ack_tog return toggle on toggle_event_rx.
package toggle_rx_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned CNT_W_DEF       = 4;
   localparam int unsigned TOT_W_DEF       = 16;

   // Occupancy class of the pending-event counter.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      SAT   = 2'd2
   } rx_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop 1-bit synchroniser, async reset to 0; shared by the event path and
// the sender-side ack path.
module sync_ff_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-link event receiver: synchronise, decode edges, queue in a saturating
// counter, hand out on valid/ready. Define TOGGLE_RX_ACK_EN for the ack_tog port.
module toggle_event_rx
   import toggle_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned TOT_W       = TOT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   input  logic             evt_ready,
   input  logic             ovf_clr,
   output logic             evt_valid,
   output logic [CNT_W-1:0] pending,
   output logic             overflow,
   output logic [TOT_W-1:0] total_cnt
`ifdef TOGGLE_RX_ACK_EN
   ,
   output logic             ack_tog
`endif
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   logic             w_tog_s;
   logic             w_det;
   logic             w_acc;
   logic             w_ovf_set;
   logic             r_tog_prev;
   logic [CNT_W-1:0] r_pending;
   logic             r_overflow;
   logic [TOT_W-1:0] r_total;
   rx_state_e        r_state;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (tog_in),
      .o_q (w_tog_s)
   );

   // Each level change of the synchronised toggle is exactly one event.
   assign w_det     = w_tog_s ^ r_tog_prev;
   assign w_acc     = evt_valid & evt_ready;
   assign w_ovf_set = w_det & ~w_acc & (r_state == SAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tog_prev <= 1'b0;
         r_pending  <= '0;
         r_total    <= '0;
         r_state    <= EMPTY;
      end else begin
         r_tog_prev <= w_tog_s;
         r_total    <= r_total + TOT_W'(w_det);
         case ({w_det, w_acc})
            2'b10: begin
               // At saturation the event is dropped; overflow records it.
               if (r_state != SAT) begin
                  r_pending <= r_pending + CNT_W'(1);
                  r_state   <= (r_pending == PEND_MAX - CNT_W'(1)) ? SAT : HOLD;
               end
            end
            2'b01: begin
               r_pending <= r_pending - CNT_W'(1);
               r_state   <= (r_pending == CNT_W'(1)) ? EMPTY : HOLD;
            end
            default: begin
               r_pending <= r_pending;
               r_state   <= r_state;
            end
         endcase
      end
   end

   // Sticky overflow; a coincident set beats the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_ovf_set) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef TOGGLE_RX_ACK_EN
   logic r_ack_tog;

   // One flip per consumed event lets the sender count outstanding events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack_tog <= 1'b0;
      end else if (w_acc) begin
         r_ack_tog <= ~r_ack_tog;
      end
   end

   assign ack_tog = r_ack_tog;
`endif

   assign evt_valid = (r_pending != '0);
   assign pending   = r_pending;
   assign overflow  = r_overflow;
   assign total_cnt = r_total;

endmodule
